imem_loader: RTL and testbench

- Program loader that fills the instruction memory the CPU reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one-cycle write pulses into the instruction-memory write port.
- Holds the CPU in reset until a complete program has been written, then releases it so fetch starts at the base address.

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the CPU instruction memory.
// Assembles big-endian words, writes them from BASE_ADDR upward, then releases the CPU.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  // state    | meaning
  // IDLE     | after reset, waiting for start; CPU held in reset
  // LEN_HI   | waiting for length byte N[15:8]
  // LEN_LO   | waiting for length byte N[7:0], then range check
  // DATA     | streaming 4*N bytes, one write pulse per completed word
  // FINISH   | write pulse of the final word is on the bus
  // DONE     | program loaded, CPU released; start reloads
  // ERROR    | length rejected, CPU still held; start reloads
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_FINISH, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_cpu_reset;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_loaded;
  logic [15:0] r_len;
  logic [15:0] r_widx;
  logic [1:0]  r_bidx;
  logic [23:0] r_asm;

  logic        w_hs;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic [31:0] w_word;
  logic [31:0] w_addr;
  logic        w_last;

  assign w_hs      = in_valid & r_in_ready;
  assign w_len     = {r_len[15:8], in_data};
  assign w_len_bad = (w_len == 16'd0) || (32'(w_len) > MAX_WORDS);
  assign w_word    = {r_asm, in_data};
  assign w_addr    = BASE_ADDR + {14'd0, r_widx, 2'b00};
  assign w_last    = (r_widx + 16'd1) == r_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= BASE_ADDR;
      r_imem_wdata   <= 32'd0;
      r_cpu_reset    <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= 16'd0;
      r_len          <= 16'd0;
      r_widx         <= 16'd0;
      r_bidx         <= 2'd0;
      r_asm          <= 24'd0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state        <= S_LEN_HI;
            r_in_ready     <= 1'b1;
            r_cpu_reset    <= 1'b1;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= 16'd0;
          end
        end
        S_LEN_HI: begin
          if (w_hs) begin
            r_len[15:8] <= in_data;
            r_state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_hs) begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state    <= S_ERROR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= S_DATA;
              r_bidx  <= 2'd0;
              r_widx  <= 16'd0;
            end
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_asm  <= w_word[23:0];
            r_bidx <= r_bidx + 2'd1;
            // byte 3 completes the word; the write strobe shows up the following cycle
            if (r_bidx == 2'd3) begin
              r_imem_we      <= 1'b1;
              r_imem_wdata   <= w_word;
              r_imem_addr    <= w_addr;
              r_words_loaded <= r_words_loaded + 16'd1;
              r_widx         <= r_widx + 16'd1;
              if (w_last) begin
                r_state    <= S_FINISH;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        S_FINISH: begin
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_cpu_reset <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives byte streams, captures write pulses
// and compares them against hand-computed programs.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  tx[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  imem_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // write pulses are one full cycle wide, so each is seen once on the falling edge
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("rdy_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int maxgap);
    foreach (tx[i]) begin
      if (maxgap > 0 && i > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, maxgap)) @(negedge clk);
      end
      send_byte(tx[i]);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_cnt"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], exp_addr[i]);
      check({tag, "_data"}, wr_data[i], exp_data[i]);
    end
  endtask

  task automatic check_finish_and_done(input string tag, input logic [15:0] nwords);
    check({tag, "_fin_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_fin_done"}, {31'd0, done}, 32'd0);
    check({tag, "_fin_we"}, {31'd0, imem_we}, 32'd1);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, {16'd0, nwords});
  endtask

  task automatic set_basic_prog();
    tx = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    exp_addr = '{32'h0000_0000, 32'h0000_0004};
    exp_data = '{32'h2008_0005, 32'h0000_000C};
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;

    #12;
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // basic back-to-back load
    clear_writes();
    set_basic_prog();
    pulse_start();
    check("basic_busy", {31'd0, busy}, 32'd1);
    send_stream(0);
    check_finish_and_done("basic", 16'd2);
    check_writes("basic");

    // same program with gaps between bytes
    clear_writes();
    set_basic_prog();
    pulse_start();
    check("gap_done_clr", {31'd0, done}, 32'd0);
    send_stream(3);
    check_finish_and_done("gap", 16'd2);
    repeat (3) @(negedge clk);
    check_writes("gap");

    // zero length header
    clear_writes();
    tx = '{8'h00, 8'h00};
    pulse_start();
    send_stream(0);
    check("len0_error", {31'd0, error}, 32'd1);
    check("len0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("len0_in_ready", {31'd0, in_ready}, 32'd0);
    check("len0_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check_writes("len0");

    // one past MAX_WORDS
    clear_writes();
    tx = '{8'h01, 8'h01};
    pulse_start();
    check("len257_err_clr", {31'd0, error}, 32'd0);
    send_stream(0);
    check("len257_error", {31'd0, error}, 32'd1);
    check("len257_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_writes("len257");

    // exactly MAX_WORDS
    clear_writes();
    tx = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'h5A, 8'(i) ^ 8'h3C};
      tx.push_back(w[31:24]);
      tx.push_back(w[23:16]);
      tx.push_back(w[15:8]);
      tx.push_back(w[7:0]);
      exp_addr.push_back(32'(4 * i));
      exp_data.push_back(w);
    end
    pulse_start();
    send_stream(0);
    check("len256_error", {31'd0, error}, 32'd0);
    check_finish_and_done("len256", 16'd256);
    check("len256_last_addr", imem_addr, 32'h0000_03FC);
    check_writes("len256");

    // start pulsed mid-DATA is ignored
    clear_writes();
    tx = '{8'h00, 8'h02, 8'h20, 8'h08};
    pulse_start();
    send_stream(0);
    pulse_start();
    check("startdata_busy", {31'd0, busy}, 32'd1);
    check("startdata_ready", {31'd0, in_ready}, 32'd1);
    tx = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    exp_addr = '{32'h0000_0000, 32'h0000_0004};
    exp_data = '{32'h2008_0005, 32'h0000_000C};
    send_stream(0);
    check_finish_and_done("startdata", 16'd2);
    check_writes("startdata");

    // start from DONE restarts at BASE_ADDR
    clear_writes();
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("restart_words", {16'd0, words_loaded}, 32'd0);
    tx = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_addr = '{32'h0000_0000};
    exp_data = '{32'h1122_3344};
    send_stream(0);
    check_finish_and_done("restart", 16'd1);
    check_writes("restart");

    // asynchronous reset after six data bytes
    clear_writes();
    tx = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    pulse_start();
    send_stream(0);
    check("midload_words_pre", {16'd0, words_loaded}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midload_words", {16'd0, words_loaded}, 32'd0);
    check("midload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("midload_in_ready", {31'd0, in_ready}, 32'd0);
    check("midload_busy", {31'd0, busy}, 32'd0);
    check("midload_addr", imem_addr, 32'h0);
    check("midload_wdata", imem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midload_idle_ready", {31'd0, in_ready}, 32'd0);
    clear_writes();
    tx = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_addr = '{32'h0000_0000};
    exp_data = '{32'hAABB_CCDD};
    pulse_start();
    send_stream(0);
    check_finish_and_done("fresh", 16'd1);
    check_writes("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
